dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters:
//   m0 = pipeline MEM stage, m1 = DMA/debug loader.
//   Performs at most one access per cycle and forwards it to dmem, which reads combinationally and writes on posedge.
//   Registers read data and returns it with a one-cycle rvalid pulse.
//   Enforces a starvation limit on the lower-priority master and filters out-of-range accesses.
// PARAMETERS
//   DEPTH_WORDS  256           words in the attached dmem; legal range is [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
//   BASE_ADDR    32'h0000_0000 byte base of dmem mapping
//   MAX_BURST    4             max consecutive m0 grants while m1 waits (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous reset, active low
//   m0_req     in   1   m0 access request; fields held stable until m0_gnt
//   m0_we      in   1   1 = write, 0 = read
//   m0_addr    in   32  byte address
//   m0_wd      in   32  write data
//   m0_be      in   4   byte enables
//   m0_gnt     out  1   access performed this cycle (combinational)
//   m0_rvalid  out  1   read data valid (1-cycle pulse)
//   m0_rdata   out  32  registered read data
//   m0_err     out  1   out-of-range access (1-cycle pulse)
//   m1_*       --   --  identical set for m1
//   mem_addr   out  32  to dmem Addr
//   mem_wd     out  32  to dmem WD
//   mem_be     out  4   to dmem BE
//   mem_we     out  1   to dmem WE
//   mem_rdata  in   32  from dmem read_data
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     rvalid/err/rdata regs = 0; last_gnt = 0 (m0); burst_cnt = 0.
//     gnt and mem_we forced 0 while rst_n=0; in-flight rvalid/err is dropped.
//   Selection, combinational from req plus state:
//     - One requester: grant it.
//     - Both requesting: grant m0, unless burst_cnt == MAX_BURST; then grant m1.
//   Burst counter:
//     - Increments on each m0 grant while m1_req=1.
//     - Clears on any m1 grant or when m1_req=0.
//     - Saturates at MAX_BURST.
//   last_gnt updates on every grant.
//   Idle cycle: mem_we=0, mem_be=0, mem_addr=0, mem_wd=0.
//   Granted cycle: mem_* mirror the selected master.
//     In range: mem_we = we.
//     Out of range (addr-BASE_ADDR >= 4*DEPTH_WORDS, unsigned): mem_we=0 and mem_be=0.
//   Read grant in cycle N:
//     mem_rdata captured at end of N (0 if out of range) -> rX_rdata.
//     mX_rvalid=1 in N+1 only; rdata holds until that master's next read.
//   Write grant: no rvalid; data lands in dmem at the end of N.
//     A read of the same word granted in N+1 returns the new data.
//   Out-of-range access (read or write): mX_err=1 in N+1 only.
//   Back-to-back: a master may be granted every cycle; rvalid of N overlaps gnt of N+1.
//   Latency: write 0 cycles to gnt; read data 1 cycle after gnt.
// CONFIGURATION
//   DMEM_ARB_RR_EN defined:
//     - Both requesting -> grant the master != last_gnt (round robin).
//     - burst_cnt held at 0; MAX_BURST ignored.
//     - First contended grant after reset goes to m1.
//   Undefined: fixed m0 priority with the MAX_BURST starvation guard above.
// STRUCTURE
//   dmem_arb_pkg:
//     - localparams M0=1'b0, M1=1'b1.
//     - Request struct typedef {we, addr[31:0], wd[31:0], be[3:0]}.
//     - Function in_range(addr, BASE_ADDR, DEPTH_WORDS).
//   Sub-module dmem_arb_pick: combinational picker.
//     - Inputs: req[1:0], last_gnt, burst_cnt; output: sel.
//     - Contains the DMEM_ARB_RR_EN split.
//   Top: state regs, mux to mem_*, range check, response regs.
// TESTING
//   1. Reset mid-read: assert rst_n=0 in the rvalid cycle
//      -> rvalid, err, rdata = 0 immediately; gnt=0 while in reset.
//   2. m0 write 0x00000010 WD=0xDEADBEEF BE=4'hF, then read 0x10 next cycle
//      -> gnt both cycles; m0_rvalid=1 with 0xDEADBEEF.
//   3. Byte merge: write 0x11223344 BE=4'hF, then 0x000000AA BE=4'h1, then read
//      -> rdata 0x112233AA.
//   4. Both req every cycle, MAX_BURST=4, RR undefined
//      -> grant pattern m0,m0,m0,m0,m1 repeating; m1 never waits >4 cycles.
//   5. DMEM_ARB_RR_EN, both req continuously from reset -> m1,m0,m1,m0 ...
//   6. Out-of-range: m1 write 0x00000400 (DEPTH_WORDS=256)
//      -> mem_we=0; m1_err=1 next cycle; memory unchanged.
//      Out-of-range read -> rvalid=1, rdata=0, err=1.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared master ids, request record and address range check for the dmem arbiter.
package dmem_arb_pkg;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;
  // Unsigned offset compare, so addresses below base wrap high and fall out of range.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int unsigned depth);
    return (addr - base) < 32'(depth * 4);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's handshake and response port onto the dmem arbiter.
interface dmem_arbiter_if;
  logic        req, we, gnt, rvalid, err;
  logic [31:0] addr, wd, rdata;
  logic [3:0]  be;
  modport master(output req, we, addr, wd, be, input gnt, rvalid, rdata, err);
  modport slave(input req, we, addr, wd, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter_pick.sv
// dmem_arb_pick: picks the dmem owner for this cycle.
// DMEM_ARB_RR_EN selects round robin; otherwise m0 priority with a starvation guard for m1.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = 3
) (
  input  logic [1:0]    req,
  input  logic          last_gnt,
  input  logic [CW-1:0] burst_cnt,
  output logic          sel
);
`ifdef DMEM_ARB_RR_EN
  assign sel = &req ? ~last_gnt : req[1];
`else
  // The counter only reaches MAX_BURST straight after an m0 grant.
  assign sel = &req ? (burst_cnt == CW'(MAX_BURST) && last_gnt == M0) : req[1];
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between m0 (MEM stage) and m1 (DMA/debug).
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of m0 priority with MAX_BURST guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  output logic [31:0]    mem_addr,
  output logic [31:0]    mem_wd,
  output logic [3:0]     mem_be,
  output logic           mem_we,
  input  logic [31:0]    mem_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [1:0]    req, gnt, rvalid_q, rvalid_d, err_q, err_d;
  logic          sel, any, ok, last_gnt_q, last_gnt_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [31:0]   rd, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  req_t          r;
  // Requests are masked in reset so nothing is granted or written.
  assign req = {m1.req, m0.req} & {2{rst_n}};
  dmem_arb_pick #(.MAX_BURST(MAX_BURST), .CW(CW)) u_pick (
    .req       (req),
    .last_gnt  (last_gnt_q),
    .burst_cnt (burst_q),
    .sel       (sel)
  );
  always_comb begin
    any        = |req;
    r          = (sel == M1) ? {m1.we, m1.addr, m1.wd, m1.be} : {m0.we, m0.addr, m0.wd, m0.be};
    ok         = in_range(r.addr, BASE_ADDR, DEPTH_WORDS);
    gnt        = any ? ((sel == M1) ? 2'b10 : 2'b01) : 2'b00;
    mem_addr   = any ? r.addr : '0;
    mem_wd     = any ? r.wd : '0;
    mem_be     = (any && ok) ? r.be : '0;
    mem_we     = any && ok && r.we;
    rd         = ok ? mem_rdata : '0;
    rvalid_d   = gnt & {2{~r.we}};
    err_d      = gnt & {2{~ok}};
    rdata0_d   = rvalid_d[0] ? rd : rdata0_q;
    rdata1_d   = rvalid_d[1] ? rd : rdata1_q;
    last_gnt_d = any ? sel : last_gnt_q;
`ifdef DMEM_ARB_RR_EN
    burst_d    = '0;
`else
    burst_d    = (gnt[0] && req[1]) ? ((burst_q == CW'(MAX_BURST)) ? burst_q : burst_q + 1'b1) : '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= M0;
      burst_q    <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      burst_q    <= burst_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end
  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.err    = err_q[0];
  assign m1.err    = err_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
endmodule
